// File: rtl/tile_render_sched_pkg.sv
// Shared render definitions: tile geometry, tile-index width and scheduler FSM encoding.
// Used by tile_render_sched, tile_grid_cnt and the tile renderer.
package tile_render_sched_pkg;

  localparam int unsigned TileSize  = 16;  // tile edge in pixels
  localparam int unsigned TileShift = 4;   // log2(TileSize)
  localparam int unsigned TileIdxW  = 8;   // tile-map entry width
  localparam int unsigned TileAddrW = 19;  // tile pixel-store address width
  localparam int unsigned PixW      = 10;  // destination pixel coordinate width
  localparam int unsigned MapAddrW  = 11;  // tile-map address width
  localparam int unsigned GridW     = PixW - TileShift;  // col/row width so that *16 fits PixW

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StIssue,
    StWait,
    StNext,
    StFin
  } sched_state_e;

  // Each tile occupies 256 bytes of pixel store; address wraps mod 2^19.
  function automatic logic [TileAddrW-1:0] tile_src_addr(input logic [TileAddrW-1:0] base,
                                                         input logic [TileIdxW-1:0]  idx);
    return base + TileAddrW'({idx, 8'b0});
  endfunction

endpackage

// File: rtl/tile_grid_cnt.sv
// Tile grid walker: col/row position and the matching linear tile-map address.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clear      - restart at tile (0,0)
//   step       - advance one tile in raster order
//   col, row   - current tile coordinates
//   map_addr   - row*COLS+col, kept incrementally
//   last       - current tile is the final tile of the frame
module tile_grid_cnt
  import tile_render_sched_pkg::*;
#(
  parameter int unsigned COLS = 40,
  parameter int unsigned ROWS = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                step,
  output logic [GridW-1:0]    col,
  output logic [GridW-1:0]    row,
  output logic [MapAddrW-1:0] map_addr,
  output logic                last
);

  if (COLS * ROWS > 2048) begin : gen_bad_map_size
    $error("COLS*ROWS must not exceed 2048");
  end
  if (COLS > 64 || ROWS > 64) begin : gen_bad_grid
    $error("COLS and ROWS must keep col*16/row*16 within 10 bits");
  end

  localparam logic [GridW-1:0] ColLast = GridW'(COLS - 1);
  localparam logic [GridW-1:0] RowLast = GridW'(ROWS - 1);

  logic col_last;
  assign col_last = (col == ColLast);
  assign last     = col_last && (row == RowLast);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col      <= '0;
      row      <= '0;
      map_addr <= '0;
    end else if (step) begin
      if (col_last) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      // Raster order makes the linear address a plain increment.
      map_addr <= map_addr + 1'b1;
    end
  end

endmodule

// File: rtl/tile_render_sched.sv
// Frame scheduler: walks the tile map in raster order and launches one renderer job per
// nonempty tile, waiting for each job to finish before moving on.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   start                         - request one frame (ignored while busy)
//   busy, done                    - frame in progress / one-cycle frame-end pulse
//   map_addr, map_data            - tile-map read port, data one cycle after address
//   rt_tile_addr, rt_top, rt_left - job parameters, stable from launch until next LATCH
//   rt_start, rt_done             - job launch pulse / job complete pulse
module tile_render_sched
  import tile_render_sched_pkg::*;
#(
  parameter int unsigned          COLS      = 40,
  parameter int unsigned          ROWS      = 30,
  parameter logic [TileAddrW-1:0] TILE_BASE = 19'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [MapAddrW-1:0]  map_addr,
  input  logic [TileIdxW-1:0]  map_data,
  output logic [TileAddrW-1:0] rt_tile_addr,
  output logic [PixW-1:0]      rt_top,
  output logic [PixW-1:0]      rt_left,
  output logic                 rt_start,
  input  logic                 rt_done
);

  sched_state_e state_q, state_d;

  logic             clear, step, last, load;
  logic [GridW-1:0] col, row;

  tile_grid_cnt #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_grid (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .step    (step),
    .col     (col),
    .row     (row),
    .map_addr(map_addr),
    .last    (last)
  );

  assign clear = (state_q == StIdle) && start;
  assign step  = (state_q == StNext) && !last;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: state_d = StLatch;  // covers tile-map read latency
      StLatch: begin
        if (map_data == '0) begin
          state_d = StNext;  // empty tile, nothing to render
        end else begin
          load    = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait:  if (rt_done) state_d = StNext;
      StNext:  state_d = last ? StFin : StFetch;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rt_tile_addr <= '0;
      rt_top       <= '0;
      rt_left      <= '0;
    end else if (load) begin
      rt_tile_addr <= tile_src_addr(TILE_BASE, map_data);
      rt_top       <= {row, TileShift'(0)};
      rt_left      <= {col, TileShift'(0)};
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFin);
  assign rt_start = (state_q == StIssue);

endmodule

// File: tb/tb_tile_render_sched.sv
// Bench for tile_render_sched on a 2x2 grid with a tile-map ROM and a renderer model.
module tb_tile_render_sched;

  localparam int unsigned COLS = 2;
  localparam int unsigned ROWS = 2;
  localparam int unsigned NT   = COLS * ROWS;
  localparam int unsigned TMO  = 1000;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, rt_start, rt_done;
  logic [10:0] map_addr;
  logic [7:0]  map_data;
  logic [18:0] rt_tile_addr;
  logic [9:0]  rt_top, rt_left;

  tile_render_sched #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .TILE_BASE(19'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .map_addr    (map_addr),
    .map_data    (map_data),
    .rt_tile_addr(rt_tile_addr),
    .rt_top      (rt_top),
    .rt_left     (rt_left),
    .rt_start    (rt_start),
    .rt_done     (rt_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Tile-map ROM, one cycle read latency.
  logic [7:0] rom [NT];
  always @(posedge clk) map_data <= (map_addr < 11'(NT)) ? rom[map_addr] : 8'h00;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Renderer model and monitor, both at the falling edge.
  int unsigned lat = 5;
  int          cnt = 0;
  logic        model_done = 1'b0;
  logic        inj_done = 1'b0;
  assign rt_done = model_done | inj_done;

  logic [38:0] jobs[$];
  logic [10:0] addr_log[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          first_rs_cyc = -1;
  logic        prev_busy = 1'b0;
  logic [10:0] prev_addr = '0;

  always @(negedge clk) begin
    model_done = 1'b0;
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) model_done = 1'b1;
    end
    if (rt_start) begin
      cnt = lat;
      if (jobs.size() == 0) first_rs_cyc = cyc;
      jobs.push_back({rt_tile_addr, rt_top, rt_left});
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (busy && (!prev_busy || map_addr != prev_addr)) addr_log.push_back(map_addr);
    prev_busy = busy;
    prev_addr = map_addr;
  end

  // Reference: one job per nonempty tile in raster order; cycle cost per tile is
  // FETCH+LATCH+NEXT, plus ISSUE and lat WAIT cycles when a job is launched; then FIN.
  logic [38:0] exp_jobs[$];
  int          exp_len;
  function automatic void build_model(input int unsigned l);
    exp_jobs.delete();
    exp_len = 0;
    for (int t = 0; t < int'(NT); t++) begin
      if (rom[t] != 8'd0) begin
        exp_jobs.push_back({19'(int'(rom[t]) * 256), 10'((t / COLS) * 16),
                            10'((t % COLS) * 16)});
        exp_len += 4 + int'(l);
      end else begin
        exp_len += 3;
      end
    end
    exp_len += 1;
  endfunction

  int start_cyc;
  bit timed_out;

  task automatic clear_logs();
    jobs.delete();
    addr_log.delete();
    done_cnt     = 0;
    first_rs_cyc = -1;
  endtask

  task automatic run_frame();
    @(negedge clk);
    #1;
    clear_logs();
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start     = 1'b0;
    timed_out = 1'b1;
    for (int n = 0; n < int'(TMO); n++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; inj_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks += 7;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    if (rt_start !== 1'b0) begin
      failures++; $display("FAIL reset_rt_start got=%b want=0", rt_start);
    end
    if (map_addr !== 11'd0) begin
      failures++; $display("FAIL reset_map_addr got=%0d want=0", map_addr);
    end
    if (rt_tile_addr !== 19'd0) begin
      failures++; $display("FAIL reset_tile_addr got=%0d want=0", rt_tile_addr);
    end
    if (rt_top !== 10'd0) begin failures++; $display("FAIL reset_top got=%0d want=0", rt_top); end
    if (rt_left !== 10'd0) begin
      failures++; $display("FAIL reset_left got=%0d want=0", rt_left);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_map();
    for (int t = 0; t < int'(NT); t++) rom[t] = 8'(t + 1);
    lat = 5;
    build_model(lat);
    run_frame();
    checks += 5;
    if (timed_out) begin failures++; $display("FAIL full_timeout got=no_done want=done"); end
    if (jobs.size() != 4) begin
      failures++; $display("FAIL full_job_count got=%0d want=4", jobs.size());
    end
    for (int i = 0; i < 4 && i < jobs.size(); i++) begin
      checks++;
      if (jobs[i] !== exp_jobs[i]) begin
        failures++;
        $display("FAIL full_job%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", i, jobs[i][38:20],
                 jobs[i][19:10], jobs[i][9:0], exp_jobs[i][38:20], exp_jobs[i][19:10],
                 exp_jobs[i][9:0]);
      end
    end
    if (first_rs_cyc != start_cyc + 3) begin
      failures++; $display("FAIL full_first_launch got=%0d want=%0d", first_rs_cyc, start_cyc + 3);
    end
    if (done_cnt != 1) begin failures++; $display("FAIL full_done_count got=%0d want=1", done_cnt); end
    if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_sparse_map();
    rom[0] = 8'd0; rom[1] = 8'd5; rom[2] = 8'd0; rom[3] = 8'd0;
    lat = 5;
    run_frame();
    checks += 3;
    if (jobs.size() != 1) begin
      failures++; $display("FAIL sparse_job_count got=%0d want=1", jobs.size());
    end else if (jobs[0] !== {19'd1280, 10'd0, 10'd16}) begin
      failures++;
      $display("FAIL sparse_job got=(%0d,%0d,%0d) want=(1280,0,16)", jobs[0][38:20],
               jobs[0][19:10], jobs[0][9:0]);
    end
    if (done_cnt != 1 || timed_out) begin
      failures++; $display("FAIL sparse_done got=%0d want=1", done_cnt);
    end
    if (busy !== 1'b0) begin failures++; $display("FAIL sparse_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_empty_map();
    for (int t = 0; t < int'(NT); t++) rom[t] = 8'd0;
    build_model(lat);
    run_frame();
    checks += 3;
    if (jobs.size() != 0) begin
      failures++; $display("FAIL empty_jobs got=%0d want=0", jobs.size());
    end
    if (done_cnt != 1 || timed_out) begin
      failures++; $display("FAIL empty_done got=%0d want=1", done_cnt);
    end
    if (done_cyc != start_cyc + exp_len) begin
      failures++;
      $display("FAIL empty_done_latency got=%0d want=%0d", done_cyc - start_cyc, exp_len);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int t = 0; t < int'(NT); t++) begin
        rom[t] = ($urandom_range(1, 0) == 0) ? 8'd0 : 8'($urandom_range(255, 1));
      end
      lat = $urandom_range(6, 1);
      build_model(lat);
      run_frame();
      checks += 3;
      if (jobs.size() != exp_jobs.size()) begin
        failures++;
        $display("FAIL rand%0d_job_count got=%0d want=%0d", it, jobs.size(), exp_jobs.size());
      end else begin
        for (int i = 0; i < jobs.size(); i++) begin
          checks++;
          if (jobs[i] !== exp_jobs[i]) begin
            failures++;
            $display("FAIL rand%0d_job%0d got=%h want=%h", it, i, jobs[i], exp_jobs[i]);
          end
        end
      end
      if (done_cnt != 1 || timed_out) begin
        failures++; $display("FAIL rand%0d_done got=%0d want=1", it, done_cnt);
      end
      if (done_cyc != start_cyc + exp_len) begin
        failures++;
        $display("FAIL rand%0d_latency got=%0d want=%0d", it, done_cyc - start_cyc, exp_len);
      end
    end
  endtask

  // Stray start during tile 0 WAIT and stray rt_done during tile 1 FETCH.
  task automatic test_ignore_stray();
    for (int t = 0; t < int'(NT); t++) rom[t] = 8'(t + 1);
    lat = 5;
    build_model(lat);
    @(negedge clk);
    #1;
    clear_logs();
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < start_cyc + 5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < start_cyc + 10) @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    timed_out = 1'b1;
    for (int n = 0; n < int'(TMO); n++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (3) @(negedge clk);
    #1;
    checks += 3;
    if (jobs.size() != exp_jobs.size()) begin
      failures++; $display("FAIL stray_job_count got=%0d want=%0d", jobs.size(), exp_jobs.size());
    end else begin
      for (int i = 0; i < jobs.size(); i++) begin
        checks++;
        if (jobs[i] !== exp_jobs[i]) begin
          failures++; $display("FAIL stray_job%0d got=%h want=%h", i, jobs[i], exp_jobs[i]);
        end
      end
    end
    if (done_cnt != 1 || timed_out) begin
      failures++; $display("FAIL stray_done got=%0d want=1", done_cnt);
    end
    if (done_cyc != start_cyc + exp_len) begin
      failures++;
      $display("FAIL stray_latency got=%0d want=%0d", done_cyc - start_cyc, exp_len);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int t = 0; t < int'(NT); t++) rom[t] = 8'(t + 1);
    lat = 5;
    build_model(lat);
    @(negedge clk);
    #1;
    clear_logs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    timed_out = 1'b1;
    for (int n = 0; n < int'(TMO); n++) begin
      @(negedge clk);
      #1;
      if (jobs.size() == 2) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks += 6;
    if (timed_out) begin failures++; $display("FAIL rstmid_no_job2 got=%0d want=2", jobs.size()); end
    if (done_cnt != 0) begin failures++; $display("FAIL rstmid_done got=%0d want=0", done_cnt); end
    if (jobs.size() != 2) begin
      failures++; $display("FAIL rstmid_extra_job got=%0d want=2", jobs.size());
    end
    if (busy !== 1'b0 || rt_start !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL rstmid_ctrl got=%b%b%b want=000", busy, rt_start, done);
    end
    if (map_addr !== 11'd0) begin
      failures++; $display("FAIL rstmid_map_addr got=%0d want=0", map_addr);
    end
    if ({rt_tile_addr, rt_top, rt_left} !== 39'd0) begin
      failures++;
      $display("FAIL rstmid_job_regs got=(%0d,%0d,%0d) want=(0,0,0)", rt_tile_addr, rt_top,
               rt_left);
    end
    run_frame();
    checks += 2;
    if (jobs.size() != exp_jobs.size()) begin
      failures++; $display("FAIL restart_job_count got=%0d want=%0d", jobs.size(), exp_jobs.size());
    end else begin
      for (int i = 0; i < jobs.size(); i++) begin
        checks++;
        if (jobs[i] !== exp_jobs[i]) begin
          failures++; $display("FAIL restart_job%0d got=%h want=%h", i, jobs[i], exp_jobs[i]);
        end
      end
    end
    if (done_cnt != 1 || timed_out) begin
      failures++; $display("FAIL restart_done got=%0d want=1", done_cnt);
    end
  endtask

  // start held over the FIN cycle (ignored) and the following IDLE cycle (accepted).
  task automatic test_back_to_back();
    for (int t = 0; t < int'(NT); t++) rom[t] = (t == 2) ? 8'd0 : 8'(t + 7);
    lat = 2;
    build_model(lat);
    @(negedge clk);
    #1;
    clear_logs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    timed_out = 1'b1;
    for (int n = 0; n < int'(TMO); n++) begin
      @(negedge clk);
      #1;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b1;
    clear_logs();
    start_cyc = cyc + 1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < int'(TMO); n++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) break;
    end
    repeat (3) @(negedge clk);
    #1;
    checks += 4;
    if (timed_out) begin failures++; $display("FAIL b2b_first_done got=none want=pulse"); end
    if (addr_log.size() != 4) begin
      failures++; $display("FAIL b2b_addr_count got=%0d want=4", addr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (addr_log[i] !== 11'(i)) begin
          failures++; $display("FAIL b2b_addr%0d got=%0d want=%0d", i, addr_log[i], i);
        end
      end
    end
    if (done_cnt != 1) begin failures++; $display("FAIL b2b_done got=%0d want=1", done_cnt); end
    if (done_cyc != start_cyc + exp_len) begin
      failures++; $display("FAIL b2b_latency got=%0d want=%0d", done_cyc - start_cyc, exp_len);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    for (int t = 0; t < int'(NT); t++) rom[t] = 8'd0;
    test_reset();
    test_full_map();
    test_sparse_map();
    test_empty_map();
    test_random();
    test_ignore_stray();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
